mlp_layer_sequencer: RTL and testbench
======================================

// Module: mlp_layer_sequencer
// PURPOSE
//  Drives one shared dot-product engine (sign-magnitude, start/ready handshake) over all
//  output nodes of one dense layer. Latches the input vector and weight matrix, issues one
//  dot-product job per output node and collects the results into a single layer vector.
//  Sits between the network top-level controller and the per-layer dot-product engine.
// PARAMETERS
//  N_IN     2    inputs per node (dot-product length)
//  N_OUT    4    output nodes (engine jobs per layer pass)
//  DW       16   data width; bit DW-1 = sign, DW-2:0 = magnitude
//  TIMEOUT  255  engine watchdog limit in cycles (used only with SEQ_TIMEOUT_EN)
// PORTS
//  clk         in   1             clock
//  reset_n     in   1             synchronous, active-low reset
//  start       in   1             1-cycle request to run a layer pass
//  in_vec      in   N_IN*DW       input vector; element i at [DW*i +: DW]
//  w_mat       in   N_OUT*N_IN*DW weights; w(j,i) at [DW*(j*N_IN+i) +: DW]
//  busy        out  1             high from accepted start until done
//  done        out  1             1-cycle pulse, out_vec valid and updated
//  out_vec     out  N_OUT*DW      layer result; node j at [DW*j +: DW]
//  eng_start   out  1             1-cycle job request to engine
//  eng_in      out  N_IN*DW       engine operand: latched input vector
//  eng_w       out  N_IN*DW       engine operand: weight row of current node
//  eng_ready   in   1             engine idle/finished (high), busy (low)
//  eng_result  in   DW            engine result, valid when eng_ready rises
//  err         out  1             timeout flag (constant 0 without SEQ_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state IDLE, busy=0, done=0, eng_start=0, out_vec=0, err=0, node index=0,
//   internal result buffer cleared. Reset mid-pass aborts; no done pulse is issued.
//  FSM: IDLE -> ISSUE -> WAIT_ACK -> WAIT_RES -> (ISSUE | FINISH) -> IDLE.
//  IDLE: start=1 latches in_vec and w_mat, sets j=0, busy=1 -> ISSUE. start while busy ignored.
//  ISSUE: waits for eng_ready=1; then drives eng_start=1 for exactly one cycle,
//   eng_in/eng_w stable from this cycle until the result is captured -> WAIT_ACK.
//  WAIT_ACK: waits for eng_ready=0 (engine accepted job) -> WAIT_RES.
//  WAIT_RES: first cycle with eng_ready=1 captures eng_result into buffer[j].
//   j<N_OUT-1: j++ -> ISSUE. j==N_OUT-1 -> FINISH.
//  FINISH: out_vec <= buffer (atomic, all nodes at once), done=1 one cycle,
//   busy=0 -> IDLE. out_vec holds previous pass until then.
//  Latency per pass: N_OUT*(engine latency + 3) + 1 cycles min after start.
//  No arithmetic on results; eng_result copied bit-exact (incl. sign, -0 = 16'h8000).
//  start coincident with done (FINISH cycle) ignored; accepted earliest next cycle.
//  Inputs in_vec/w_mat may change freely after start accepted (latched copy used).
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined: cycle counter runs in WAIT_ACK and WAIT_RES, cleared on each
//   transition; reaching TIMEOUT -> err=1 (sticky until next accepted start), pass
//   aborted, busy=0, no done pulse, out_vec unchanged, -> IDLE.
//  Not defined: no counter, waits forever, err tied 0.
// TESTING
//  1 Bench engine model (3-cycle latency, sign-magnitude MAC, negative clamp to 0):
//    in={2,3}, w rows {1,1},{2,0},{0,4},{1,2} -> out_vec={5,4,12,8}, one done pulse.
//  2 in={2,16'h8003}, row0 w={1,1} -> node0 = 0 (clamped by engine); other nodes exact.
//  3 start pulsed again mid-pass and on FINISH cycle -> ignored, exactly one done,
//    eng_start pulse count = N_OUT.
//  4 reset_n=0 during WAIT_RES of node 2 -> next cycle busy=0, eng_start=0, out_vec=0,
//    no done; fresh start then completes normally.
//  5 in_vec/w_mat changed 1 cycle after start -> results match originally latched values.
//  6 SEQ_TIMEOUT_EN, engine never drops ready -> err=1 after TIMEOUT cycles, busy=0,
//    out_vec unchanged; next start clears err.

Source files
------------

// File: rtl/mlp_layer_sequencer.sv
// Dense-layer sequencer: runs one shared dot-product engine once per output node and gathers the results.
// Define SEQ_TIMEOUT_EN to enable the engine watchdog that drives err_o; without it err_o is tied low.
module mlp_layer_sequencer #(
  parameter int N_IN    = 2,
  parameter int N_OUT   = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start_i,
  input  logic [N_IN*DW-1:0]        in_vec_i,
  input  logic [N_OUT*N_IN*DW-1:0]  w_mat_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [N_OUT*DW-1:0]       out_vec_o,
  output logic                      eng_start_o,
  output logic [N_IN*DW-1:0]        eng_in_o,
  output logic [N_IN*DW-1:0]        eng_w_o,
  input  logic                      eng_ready_i,
  input  logic [DW-1:0]             eng_result_i,
  output logic                      err_o
);

  // state      | meaning
  // S_IDLE     | waiting for start_i
  // S_ISSUE    | waiting for engine ready, then pulse eng_start_o
  // S_WAIT_ACK | waiting for engine to drop ready (job accepted)
  // S_WAIT_RES | waiting for engine ready again (result valid)
  // S_FINISH   | done_o pulse, out_vec_o already holds the new layer vector
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_RES, S_FINISH} state_t;

  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  state_t                     state_q, state_d;
  logic [N_IN*DW-1:0]         in_q, in_d;
  logic [N_OUT*N_IN*DW-1:0]   w_q, w_d;
  logic [JW-1:0]              j_q, j_d;
  logic [N_OUT*DW-1:0]        buf_q, buf_d;
  logic [N_OUT*DW-1:0]        out_q, out_d;
  logic                       err_q, err_d;
  logic                       timeout;

`ifdef SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;

  assign waiting = (state_q == S_WAIT_ACK) || (state_q == S_WAIT_RES);
  assign timeout = waiting && (cnt_q == CW'(TIMEOUT - 1));

  // Counts cycles spent in the current wait state; any state change restarts it.
  always_comb begin
    cnt_d = '0;
    if (waiting && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    in_d        = in_q;
    w_d         = w_q;
    j_d         = j_q;
    buf_d       = buf_q;
    out_d       = out_q;
    err_d       = err_q;
    eng_start_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          in_d    = in_vec_i;
          w_d     = w_mat_i;
          j_d     = '0;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (eng_ready_i) begin
          eng_start_o = 1'b1;
          state_d     = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (!eng_ready_i) begin
          state_d = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (eng_ready_i) begin
          buf_d[j_q*DW +: DW] = eng_result_i;
          if (j_q == JW'(N_OUT - 1)) begin
            // Publish on entry to FINISH so out_vec_o is valid alongside done_o.
            out_d   = buf_d;
            state_d = S_FINISH;
          end else begin
            j_d     = j_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      in_q    <= '0;
      w_q     <= '0;
      j_q     <= '0;
      buf_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      w_q     <= w_d;
      j_q     <= j_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_FINISH);
  assign out_vec_o = out_q;
  assign eng_in_o  = in_q;
  assign eng_w_o   = w_q[j_q*N_IN*DW +: N_IN*DW];
  assign err_o     = err_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Bench for mlp_layer_sequencer: 3-cycle sign-magnitude MAC engine model, table of layer passes, directed corner cases.
module tb_mlp_layer_sequencer;
  localparam int N_IN = 2, N_OUT = 4, DW = 16, TIMEOUT = 255;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     start;
  logic [N_IN*DW-1:0]       in_vec;
  logic [N_OUT*N_IN*DW-1:0] w_mat;
  logic                     busy, done, eng_start, eng_ready, err;
  logic [N_OUT*DW-1:0]      out_vec;
  logic [N_IN*DW-1:0]       eng_in, eng_w;
  logic [DW-1:0]            eng_result;

  always #5 clk = ~clk;

  mlp_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start), .in_vec_i(in_vec), .w_mat_i(w_mat),
    .busy_o(busy), .done_o(done), .out_vec_o(out_vec), .eng_start_o(eng_start),
    .eng_in_o(eng_in), .eng_w_o(eng_w), .eng_ready_i(eng_ready),
    .eng_result_i(eng_result), .err_o(err)
  );

  // Engine model
  logic        stuck = 1'b0, force_en = 1'b0;
  logic [15:0] force_val = 16'h0000;
  logic        eng_busy;
  int          eng_cnt;

  function automatic int sm(logic [15:0] x);
    int m;
    m = int'({17'b0, x[14:0]});
    return x[15] ? -m : m;
  endfunction

  function automatic logic [15:0] mac(logic [31:0] a, logic [31:0] w);
    int s;
    s = 0;
    for (int i = 0; i < N_IN; i++) s += sm(a[16*i +: 16]) * sm(w[16*i +: 16]);
    if (s < 0) s = 0;
    return 16'(s);
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      eng_ready  <= 1'b1;
      eng_busy   <= 1'b0;
      eng_cnt    <= 0;
      eng_result <= '0;
    end else if (eng_busy) begin
      if (eng_cnt == 0) begin
        eng_ready <= 1'b1;
        eng_busy  <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end else if (eng_start && !stuck) begin
      eng_ready  <= 1'b0;
      eng_busy   <= 1'b1;
      eng_cnt    <= 2;
      eng_result <= force_en ? force_val : mac(eng_in, eng_w);
    end
  end

  int n_estart = 0, n_done = 0;
  always @(posedge clk) begin
    if (eng_start) n_estart <= n_estart + 1;
    if (done)      n_done   <= n_done + 1;
  end

  int n_vec = 0, n_bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk2(logic [15:0] a, logic [15:0] b);
    return {b, a};
  endfunction
  function automatic logic [127:0] pkw(logic [15:0] a0, logic [15:0] b0, logic [15:0] a1, logic [15:0] b1,
                                       logic [15:0] a2, logic [15:0] b2, logic [15:0] a3, logic [15:0] b3);
    return {b3, a3, b2, a2, b1, a1, b0, a0};
  endfunction
  function automatic logic [63:0] pk4(logic [15:0] n0, logic [15:0] n1, logic [15:0] n2, logic [15:0] n3);
    return {n3, n2, n1, n0};
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < 400 && !done; c++) @(negedge clk);
    chk(name, done, 1'b1);
  endtask

  typedef struct {
    logic [31:0]  in;
    logic [127:0] w;
    logic         fe;
    logic [15:0]  fv;
    logic [63:0]  exp;
  } vec_t;
  vec_t tbl[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, e0;
    logic [63:0] prev;

    tbl[0] = '{pk2(2, 3), pkw(1, 1, 2, 0, 0, 4, 1, 2), 1'b0, 16'h0, pk4(5, 4, 12, 8)};
    tbl[1] = '{pk2(2, 16'h8003), pkw(1, 1, 2, 0, 3, 0, 5, 1), 1'b0, 16'h0, pk4(0, 4, 6, 7)};
    tbl[2] = '{pk2(2, 3), pkw(1, 1, 2, 0, 0, 4, 1, 2), 1'b1, 16'h8000,
               pk4(16'h8000, 16'h8000, 16'h8000, 16'h8000)};
    tbl[3] = '{pk2(4, 5), pkw(16'h8001, 2, 3, 16'h8002, 0, 0, 7, 7), 1'b0, 16'h0, pk4(6, 2, 0, 63)};
    tbl[4] = '{pk2(100, 200), pkw(10, 20, 1, 0, 0, 1, 16'h8000, 3), 1'b0, 16'h0, pk4(5000, 100, 200, 600)};

    reset_n = 1'b0; start = 1'b0; in_vec = '0; w_mat = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_eng_start", eng_start, 1'b0);
    chk("rst_out_vec", out_vec, 64'h0);
    chk("rst_err", err, 1'b0);
    reset_n = 1'b1;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_vec = tbl[k].in; w_mat = tbl[k].w;
      force_en = tbl[k].fe; force_val = tbl[k].fv;
      d0 = n_done; e0 = n_estart;
      pulse_start();
      wait_done($sformatf("vec%0d_done", k));
      chk($sformatf("vec%0d_out_vec", k), out_vec, tbl[k].exp);
      @(negedge clk);
      chk($sformatf("vec%0d_busy_after", k), busy, 1'b0);
      chk($sformatf("vec%0d_done_count", k), 64'(n_done - d0), 64'd1);
      chk($sformatf("vec%0d_eng_starts", k), 64'(n_estart - e0), 64'd4);
      chk($sformatf("vec%0d_err", k), err, 1'b0);
    end
    force_en = 1'b0;

    // Restart requests mid-pass and on the FINISH cycle must be ignored.
    in_vec = tbl[1].in; w_mat = tbl[1].w;
    d0 = n_done; e0 = n_estart;
    pulse_start();
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("restart_done");
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("finish_start_ignored", busy, 1'b0);
    repeat (10) @(negedge clk);
    chk("restart_busy", busy, 1'b0);
    chk("restart_done_count", 64'(n_done - d0), 64'd1);
    chk("restart_eng_starts", 64'(n_estart - e0), 64'd4);
    chk("restart_out_vec", out_vec, tbl[1].exp);

    // Inputs change right after start; the latched copy must be used.
    prev = out_vec;
    in_vec = tbl[0].in; w_mat = tbl[0].w;
    pulse_start();
    in_vec = pk2(16'h1234, 16'h0777); w_mat = {8{16'h0055}};
    @(negedge clk);
    chk("latch_out_held", out_vec, prev);
    wait_done("latch_done");
    chk("latch_out_vec", out_vec, tbl[0].exp);

    // Reset during WAIT_RES of node 2 aborts the pass.
    @(negedge clk);
    in_vec = tbl[3].in; w_mat = tbl[3].w;
    d0 = n_done; e0 = n_estart;
    pulse_start();
    for (int c = 0; c < 100 && (n_estart - e0) < 3; c++) @(negedge clk);
    chk("rst_mid_reached_node2", 64'(n_estart - e0), 64'd3);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_eng_start", eng_start, 1'b0);
    chk("rst_mid_out_vec", out_vec, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_done", 64'(n_done - d0), 64'd0);
    in_vec = tbl[0].in; w_mat = tbl[0].w;
    pulse_start();
    wait_done("rst_mid_fresh_done");
    chk("rst_mid_fresh_out", out_vec, tbl[0].exp);

`ifdef SEQ_TIMEOUT_EN
    // Engine never acknowledges: watchdog aborts the pass.
    @(negedge clk);
    prev = out_vec;
    d0 = n_done;
    stuck = 1'b1;
    in_vec = tbl[3].in; w_mat = tbl[3].w;
    pulse_start();
    for (int c = 0; c < TIMEOUT + 50 && busy; c++) @(negedge clk);
    chk("to_busy", busy, 1'b0);
    chk("to_err", err, 1'b1);
    chk("to_out_vec", out_vec, prev);
    repeat (5) @(negedge clk);
    chk("to_err_sticky", err, 1'b1);
    chk("to_no_done", 64'(n_done - d0), 64'd0);
    stuck = 1'b0;
    pulse_start();
    chk("to_err_cleared", err, 1'b0);
    wait_done("to_recover_done");
    chk("to_recover_out", out_vec, tbl[3].exp);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
